// File: rtl/conf_slave.sv
// conf_slave -- AXI4-Lite responder with a small configuration/status bank.
//
// Register map (offset = address - BaseAddr_Gen, decoded on offset[7:2],
// offset[31:8] != 0 is unmapped):
//   0x00 Control    RW, byte strobes, reset ControlReset_Gen
//   0x04 Status     RO, live Status_DatIn
//   0x08 Version    RO, Version_Gen
//   0x0C Scratch    RW, byte strobes, reset 0
//   0x10 WriteCount RO, counts every completed write (mapped or not), wraps
//
// Ports:
//   SysClk_ClkIn / SysRstN_RstIn      clock, asynchronous reset (active-high)
//   AxiWriteAddr*  AW channel (Prot ignored)
//   AxiWriteData*  W channel
//   AxiWriteResp*  B channel
//   AxiReadAddr*   AR channel (Prot ignored)
//   AxiReadData*   R channel
//   Control_DatOut current Control register
//   Status_DatIn   live status, sampled when read
//
// Build option: CONF_SLAVE_DECERR_EN -- when defined, unmapped accesses answer
// DECERR (2'b11) and writes to read-only registers answer SLVERR (2'b10).
// When undefined every access answers OKAY.
module conf_slave #(
  parameter logic [31:0] BaseAddr_Gen     = 32'h0000_0000,
  parameter logic [31:0] Version_Gen      = 32'h0001_0000,
  parameter logic [31:0] ControlReset_Gen = 32'h0000_0000
) (
  input  logic        SysClk_ClkIn,
  input  logic        SysRstN_RstIn,
  input  logic        AxiWriteAddrValid_ValIn,
  output logic        AxiWriteAddrReady_RdyOut,
  input  logic [31:0] AxiWriteAddrAddress_AdrIn,
  input  logic [2:0]  AxiWriteAddrProt_DatIn,
  input  logic        AxiWriteDataValid_ValIn,
  output logic        AxiWriteDataReady_RdyOut,
  input  logic [31:0] AxiWriteDataData_DatIn,
  input  logic [3:0]  AxiWriteDataStrobe_DatIn,
  output logic        AxiWriteRespValid_ValOut,
  input  logic        AxiWriteRespReady_RdyIn,
  output logic [1:0]  AxiWriteRespResponse_DatOut,
  input  logic        AxiReadAddrValid_ValIn,
  output logic        AxiReadAddrReady_RdyOut,
  input  logic [31:0] AxiReadAddrAddress_AdrIn,
  input  logic [2:0]  AxiReadAddrProt_DatIn,
  output logic        AxiReadDataValid_ValOut,
  input  logic        AxiReadDataReady_RdyIn,
  output logic [1:0]  AxiReadDataResponse_DatOut,
  output logic [31:0] AxiReadDataData_DatOut,
  output logic [31:0] Control_DatOut,
  input  logic [31:0] Status_DatIn
);

  typedef enum logic [2:0] {
    RegControl, RegStatus, RegVersion, RegScratch, RegWriteCount, RegNone
  } regSel_t;

  function automatic regSel_t decode(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BaseAddr_Gen;
    if (off[31:8] != 24'd0) return RegNone;
    case (off[7:2])
      6'd0:    return RegControl;
      6'd1:    return RegStatus;
      6'd2:    return RegVersion;
      6'd3:    return RegScratch;
      6'd4:    return RegWriteCount;
      default: return RegNone;
    endcase
  endfunction

  function automatic logic [31:0] mergeStrb(input logic [31:0] old,
                                            input logic [31:0] nw,
                                            input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[i*8 +: 8] = strb[i] ? nw[i*8 +: 8] : old[i*8 +: 8];
    return res;
  endfunction

  // rdyEn keeps all readies low until the first edge after reset release.
  logic        rdyEn;
  logic        awHeld, wHeld, bValid, rValid;
  logic [31:0] awAddr, wData;
  logic [3:0]  wStrb;
  logic [1:0]  bResp, rResp;
  logic [31:0] rData;
  logic [31:0] control, scratch, writeCount;

  logic        awHs, wHs, arHs, doWrite;
  logic [31:0] curAddr, curData;
  logic [3:0]  curStrb;
  regSel_t     wSel, rSel;
  logic [1:0]  wRespNext, rRespNext;
  logic [31:0] rDataNext;
  logic        unusedBits;

  assign unusedBits = ^{AxiWriteAddrProt_DatIn, AxiReadAddrProt_DatIn};

  assign AxiWriteAddrReady_RdyOut    = rdyEn & ~awHeld & ~bValid;
  assign AxiWriteDataReady_RdyOut    = rdyEn & ~wHeld & ~bValid;
  assign AxiReadAddrReady_RdyOut     = rdyEn & ~rValid;
  assign AxiWriteRespValid_ValOut    = bValid;
  assign AxiWriteRespResponse_DatOut = bResp;
  assign AxiReadDataValid_ValOut     = rValid;
  assign AxiReadDataResponse_DatOut  = rResp;
  assign AxiReadDataData_DatOut      = rData;
  assign Control_DatOut              = control;

  assign awHs = AxiWriteAddrValid_ValIn & AxiWriteAddrReady_RdyOut;
  assign wHs  = AxiWriteDataValid_ValIn & AxiWriteDataReady_RdyOut;
  assign arHs = AxiReadAddrValid_ValIn & AxiReadAddrReady_RdyOut;

  // The write fires on the edge where the second half arrives, taking it
  // straight from the bus; this gives one write per two cycles.
  assign doWrite = (awHeld | awHs) & (wHeld | wHs);
  assign curAddr = awHeld ? awAddr : AxiWriteAddrAddress_AdrIn;
  assign curData = wHeld ? wData : AxiWriteDataData_DatIn;
  assign curStrb = wHeld ? wStrb : AxiWriteDataStrobe_DatIn;
  assign wSel    = decode(curAddr);
  assign rSel    = decode(AxiReadAddrAddress_AdrIn);

  always_comb begin
    wRespNext = 2'b00;
    rRespNext = 2'b00;
`ifdef CONF_SLAVE_DECERR_EN
    if (wSel == RegNone) wRespNext = 2'b11;
    else if (wSel == RegStatus || wSel == RegVersion || wSel == RegWriteCount)
      wRespNext = 2'b10;
    if (rSel == RegNone) rRespNext = 2'b11;
`endif
    case (rSel)
      RegControl:    rDataNext = control;
      RegStatus:     rDataNext = Status_DatIn;
      RegVersion:    rDataNext = Version_Gen;
      RegScratch:    rDataNext = scratch;
      RegWriteCount: rDataNext = writeCount;
      default:       rDataNext = 32'd0;
    endcase
  end

  always_ff @(posedge SysClk_ClkIn or posedge SysRstN_RstIn) begin
    if (SysRstN_RstIn) begin
      rdyEn      <= 1'b0;
      awHeld     <= 1'b0;
      wHeld      <= 1'b0;
      awAddr     <= 32'd0;
      wData      <= 32'd0;
      wStrb      <= 4'd0;
      bValid     <= 1'b0;
      bResp      <= 2'b00;
      rValid     <= 1'b0;
      rResp      <= 2'b00;
      rData      <= 32'd0;
      control    <= ControlReset_Gen;
      scratch    <= 32'd0;
      writeCount <= 32'd0;
    end else begin
      rdyEn  <= 1'b1;
      awHeld <= (awHeld | awHs) & ~doWrite;
      wHeld  <= (wHeld | wHs) & ~doWrite;
      if (awHs) awAddr <= AxiWriteAddrAddress_AdrIn;
      if (wHs) begin
        wData <= AxiWriteDataData_DatIn;
        wStrb <= AxiWriteDataStrobe_DatIn;
      end
      if (doWrite) begin
        bValid     <= 1'b1;
        bResp      <= wRespNext;
        writeCount <= writeCount + 32'd1;
        if (wSel == RegControl) control <= mergeStrb(control, curData, curStrb);
        if (wSel == RegScratch) scratch <= mergeStrb(scratch, curData, curStrb);
      end else if (bValid & AxiWriteRespReady_RdyIn) begin
        bValid <= 1'b0;
      end
      // Read data is sampled before any same-edge write lands: old value wins.
      if (arHs) begin
        rValid <= 1'b1;
        rData  <= rDataNext;
        rResp  <= rRespNext;
      end else if (rValid & AxiReadDataReady_RdyIn) begin
        rValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conf_slave.sv
module tb_conf_slave;

  localparam logic [31:0] Base = 32'h4000_0000;
  localparam logic [31:0] Ver  = 32'h0001_0000;
  localparam logic [31:0] CtlR = 32'h0000_0F00;
`ifdef CONF_SLAVE_DECERR_EN
  localparam logic [1:0] ExpRo  = 2'b10;
  localparam logic [1:0] ExpUnm = 2'b11;
`else
  localparam logic [1:0] ExpRo  = 2'b00;
  localparam logic [1:0] ExpUnm = 2'b00;
`endif

  logic clk = 0, rst = 1;
  logic awValid = 0, awReady, wValid = 0, wReady, bValid, bReady = 0;
  logic arValid = 0, arReady, rValid, rReady = 0;
  logic [31:0] awAddr = 0, wData = 0, arAddr = 0, rData, control, status = 0;
  logic [3:0]  wStrb = 0;
  logic [1:0]  bResp, rResp;

  typedef struct { logic [1:0] resp; logic [31:0] data; } exp_t;
  exp_t bQ[$];
  exp_t rQ[$];
  int checks = 0, failures = 0;
  logic [31:0] wcExp = 0;

  always #5 clk = ~clk;

  conf_slave #(.BaseAddr_Gen(Base), .Version_Gen(Ver), .ControlReset_Gen(CtlR)) dut (
    .SysClk_ClkIn(clk), .SysRstN_RstIn(rst),
    .AxiWriteAddrValid_ValIn(awValid), .AxiWriteAddrReady_RdyOut(awReady),
    .AxiWriteAddrAddress_AdrIn(awAddr), .AxiWriteAddrProt_DatIn(3'b000),
    .AxiWriteDataValid_ValIn(wValid), .AxiWriteDataReady_RdyOut(wReady),
    .AxiWriteDataData_DatIn(wData), .AxiWriteDataStrobe_DatIn(wStrb),
    .AxiWriteRespValid_ValOut(bValid), .AxiWriteRespReady_RdyIn(bReady),
    .AxiWriteRespResponse_DatOut(bResp),
    .AxiReadAddrValid_ValIn(arValid), .AxiReadAddrReady_RdyOut(arReady),
    .AxiReadAddrAddress_AdrIn(arAddr), .AxiReadAddrProt_DatIn(3'b000),
    .AxiReadDataValid_ValOut(rValid), .AxiReadDataReady_RdyIn(rReady),
    .AxiReadDataResponse_DatOut(rResp), .AxiReadDataData_DatOut(rData),
    .Control_DatOut(control), .Status_DatIn(status)
  );

  // Wait for B, compare against the scoreboard head, then accept it.
  task automatic wait_b(input string nm, output int lat);
    exp_t e;
    lat = 0;
    @(negedge clk);
    while (!bValid && lat < 20) begin @(negedge clk); lat++; end
    checks++;
    if (!bValid) begin
      failures++; $display("FAIL %s: bvalid timeout got=0 exp=1", nm);
      void'(bQ.pop_front());
    end else begin
      e = bQ.pop_front();
      if (bResp !== e.resp) begin
        failures++; $display("FAIL %s: bresp got=%b exp=%b", nm, bResp, e.resp);
      end
    end
    bReady = 1; @(posedge clk); #1 bReady = 0;
  endtask

  task automatic wait_r(input string nm, output int lat);
    exp_t e;
    lat = 0;
    @(negedge clk);
    while (!rValid && lat < 20) begin @(negedge clk); lat++; end
    checks++;
    if (!rValid) begin
      failures++; $display("FAIL %s: rvalid timeout got=0 exp=1", nm);
      void'(rQ.pop_front());
    end else begin
      e = rQ.pop_front();
      if (rResp !== e.resp || rData !== e.data) begin
        failures++;
        $display("FAIL %s: rresp/rdata got=%b/%h exp=%b/%h", nm, rResp, rData, e.resp, e.data);
      end
    end
    rReady = 1; @(posedge clk); #1 rReady = 0;
  endtask

  task automatic axi_write(input string nm, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] er, output int lat);
    bit awD = 0, wD = 0;
    int n = 0;
    bQ.push_back('{er, 32'd0}); wcExp++;
    awAddr = a; wData = d; wStrb = s; awValid = 1; wValid = 1;
    while (!(awD && wD) && n < 20) begin
      @(negedge clk);
      if (awValid && awReady) awD = 1;
      if (wValid && wReady) wD = 1;
      @(posedge clk); #1;
      if (awD) awValid = 0;
      if (wD) wValid = 0;
      n++;
    end
    awValid = 0; wValid = 0;
    wait_b(nm, lat);
  endtask

  task automatic axi_read(input string nm, input logic [31:0] a, input logic [1:0] er,
                          input logic [31:0] ed, output int lat);
    int n = 0;
    rQ.push_back('{er, ed});
    arAddr = a; arValid = 1;
    @(negedge clk);
    while (!arReady && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1 arValid = 0;
    wait_r(nm, lat);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({awReady, wReady, arReady, bValid, rValid} !== 5'b0 || bResp !== 2'b00 ||
        rResp !== 2'b00 || rData !== 32'd0 || control !== CtlR) begin
      failures++;
      $display("FAIL reset_state: rdy/vld=%b resp=%b/%b rdata=%h ctl=%h exp 00000/00/00/0/%h",
               {awReady, wReady, arReady, bValid, rValid}, bResp, rResp, rData, control, CtlR);
    end
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    checks++;
    if ({awReady, wReady, arReady} !== 3'b000) begin
      failures++; $display("FAIL ready_hold: got=%b exp=000", {awReady, wReady, arReady});
    end
    @(negedge clk);
    checks++;
    if ({awReady, wReady, arReady} !== 3'b111) begin
      failures++; $display("FAIL ready_rise: got=%b exp=111", {awReady, wReady, arReady});
    end
  endtask

  task automatic test_basic_write;
    int lat;
    axi_write("wr_ctrl", Base, 32'h0000_00A5, 4'hF, 2'b00, lat);
    checks++;
    if (lat != 0) begin failures++; $display("FAIL wr_latency: got=%0d exp=0", lat); end
    checks++;
    if (control !== 32'h0000_00A5) begin
      failures++; $display("FAIL ctl_out: got=%h exp=000000a5", control);
    end
    axi_read("rd_wcount1", Base + 32'h10, 2'b00, wcExp, lat);
  endtask

  task automatic test_w_before_aw;
    int lat;
    bit bad = 0;
    exp_t e;
    wData = 32'h1234_5678; wStrb = 4'b0101; wValid = 1;
    repeat (3) begin
      @(negedge clk);
      @(posedge clk); #1;
      if (!wReady) wValid = 0;
    end
    wValid = 0;
    checks++;
    if (wReady !== 1'b0 || bValid !== 1'b0) begin
      failures++; $display("FAIL w_held: wready/bvalid got=%b%b exp=00", wReady, bValid);
    end
    bQ.push_back('{2'b00, 32'd0}); wcExp++;
    awAddr = Base + 32'h0C; awValid = 1;
    @(negedge clk);
    @(posedge clk); #1 awValid = 0;
    @(negedge clk);
    checks++;
    if (!bValid) begin
      failures++; $display("FAIL w_first_b: bvalid got=0 exp=1");
      void'(bQ.pop_front());
    end else begin
      e = bQ.pop_front();
      if (bResp !== e.resp) begin
        failures++; $display("FAIL w_first_b: bresp got=%b exp=%b", bResp, e.resp);
      end
    end
    repeat (4) begin
      if (awReady || wReady || !bValid) bad = 1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin failures++; $display("FAIL b_stall: readies rose or bvalid dropped got=1 exp=0"); end
    bReady = 1; @(posedge clk); #1 bReady = 0;
    @(negedge clk);
    checks++;
    if (bValid !== 1'b0 || awReady !== 1'b1) begin
      failures++; $display("FAIL b_release: bvalid/awready got=%b%b exp=01", bValid, awReady);
    end
    axi_read("rd_scratch_strb", Base + 32'h0C, 2'b00, 32'h0034_0078, lat);
  endtask

  task automatic test_read;
    int lat;
    status = 32'hDEAD_BEEF;
    axi_read("rd_version", Base + 32'h08, 2'b00, Ver, lat);
    checks++;
    if (lat != 0) begin failures++; $display("FAIL rd_latency: got=%0d exp=0", lat); end
    axi_read("rd_status", Base + 32'h04, 2'b00, 32'hDEAD_BEEF, lat);
  endtask

  task automatic test_unmapped;
    int lat;
    axi_read("rd_unmapped", Base + 32'h40, ExpUnm, 32'd0, lat);
    axi_read("rd_far", Base + 32'h100, ExpUnm, 32'd0, lat);
    axi_write("wr_ro", Base + 32'h08, 32'hFFFF_FFFF, 4'hF, ExpRo, lat);
    axi_read("rd_version_kept", Base + 32'h08, 2'b00, Ver, lat);
    axi_read("rd_wcount", Base + 32'h10, 2'b00, wcExp, lat);
  endtask

  task automatic test_same_cycle;
    int lat;
    axi_write("wr_scr1", Base + 32'h0C, 32'h1, 4'hF, 2'b00, lat);
    bQ.push_back('{2'b00, 32'd0}); rQ.push_back('{2'b00, 32'h1}); wcExp++;
    awAddr = Base + 32'h0C; wData = 32'h2; wStrb = 4'hF; arAddr = Base + 32'h0C;
    awValid = 1; wValid = 1; arValid = 1;
    @(negedge clk);
    checks++;
    if ({awReady, wReady, arReady} !== 3'b111) begin
      failures++; $display("FAIL same_rdy: got=%b exp=111", {awReady, wReady, arReady});
    end
    @(posedge clk); #1 awValid = 0; wValid = 0; arValid = 0;
    wait_r("same_rd_old", lat);
    wait_b("same_wr", lat);
    axi_read("same_rd_new", Base + 32'h0C, 2'b00, 32'h2, lat);
  endtask

  task automatic test_back_to_back;
    int whs = 0, rhs = 0;
    bReady = 1; rReady = 1;
    awAddr = Base + 32'h0C; wData = 32'h77; wStrb = 4'hF; awValid = 1; wValid = 1;
    repeat (6) begin
      @(negedge clk); if (awValid && awReady && wReady) whs++;
      @(posedge clk); #1;
    end
    awValid = 0; wValid = 0; wcExp += 3;
    arAddr = Base + 32'h0C; arValid = 1;
    repeat (6) begin
      @(negedge clk); if (arValid && arReady) rhs++;
      @(posedge clk); #1;
    end
    arValid = 0;
    @(posedge clk); #1 bReady = 0; rReady = 0;
    checks++;
    if (whs != 3 || rhs != 3) begin
      failures++; $display("FAIL b2b_rate: writes/reads got=%0d/%0d exp=3/3", whs, rhs);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    bit bad = 0;
    axi_read("rd_wcount_pre", Base + 32'h10, 2'b00, wcExp, lat);
    awAddr = Base; awValid = 1;
    @(negedge clk);
    @(posedge clk); #1 awValid = 0;
    wData = 32'h0000_0055; wStrb = 4'hF; wValid = 1; rst = 1;
    @(negedge clk);
    checks++;
    if (control !== CtlR || {awReady, wReady, arReady} !== 3'b000) begin
      failures++; $display("FAIL mid_reset: ctl/rdy got=%h/%b exp=%h/000", control,
                           {awReady, wReady, arReady}, CtlR);
    end
    @(posedge clk); #1 wValid = 0;
    @(posedge clk); #1 rst = 0; wcExp = 0;
    repeat (4) begin @(negedge clk); if (bValid || rValid) bad = 1; end
    checks++;
    if (bad || {awReady, wReady, arReady} !== 3'b111 || control !== CtlR) begin
      failures++; $display("FAIL post_reset: stray=%b rdy=%b ctl=%h exp 0/111/%h", bad,
                           {awReady, wReady, arReady}, control, CtlR);
    end
    axi_read("rd_ctl_reset", Base, 2'b00, CtlR, lat);
    axi_read("rd_wcount_reset", Base + 32'h10, 2'b00, wcExp, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_basic_write;
    test_w_before_aw;
    test_read;
    test_unmapped;
    test_same_cycle;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
